frame_scanout: RTL and testbench

//  Downstream of the multi-solver array. Once all solvers report done, walks the frame in raster order.

---
 rtl/frame_scanout_pkg.sv | 13 +
 rtl/frame_scanout_if.sv | 23 ++
 rtl/frame_scanout_colormap.sv | 12 +
 rtl/frame_scanout.sv | 109 ++++++++++
 tb/tb_frame_scanout.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_scanout_pkg.sv
// Shared widths and FSM state type for the frame scan-out block.
package frame_scanout_pkg;
  localparam int ADDR_W = 19;
  localparam int SID_W  = 6;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    FLUSH
  } state_t;
endpackage

// File: rtl/frame_scanout_if.sv
// Solver read port plus outgoing pixel stream, bundled for the scan-out block.
interface frame_scanout_if;
  import frame_scanout_pkg::*;

  logic [SID_W-1:0]        rd_solver_id;
  logic [ADDR_W-1:0]       rd_addr;
  logic signed [PIX_W-1:0] rd_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [PIX_W-1:0]        pix_data;
  logic                    pix_sof;
  logic                    pix_eol;

  modport master (
    output rd_solver_id, rd_addr, pix_valid, pix_data, pix_sof, pix_eol,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_solver_id, rd_addr, pix_valid, pix_data, pix_sof, pix_eol,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/frame_scanout_colormap.sv
// RGB332 colour mapping of signed solver data; negative (in-set) values map to black.
module scanout_colormap
  import frame_scanout_pkg::*;
(
  input  logic signed [PIX_W-1:0] raw,
  output logic [PIX_W-1:0]        rgb
);
  always_comb begin
    rgb = '0;
    if (!raw[PIX_W-1]) rgb = {raw[2:0], raw[5:3], raw[6], raw[6]};
  end
endmodule

// File: rtl/frame_scanout.sv
// Raster-order frame scan-out from the solver RAMs onto a valid/ready pixel stream.
// Optional RGB332 output mapping is enabled by defining SCANOUT_COLORMAP_EN.
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             solver_done,
  output logic             busy,
  output logic             frame_done,
  frame_scanout_if.master  bus
);
  state_t            state;
  logic [ADDR_W-1:0] x, y, addr;
  logic [SID_W-1:0]  sid;
  logic              pix_valid, pix_sof, pix_eol;
  logic [PIX_W-1:0]  pix_data, pix_next;
  logic              slot_free, pop, last_pix;

`ifdef SCANOUT_COLORMAP_EN
  scanout_colormap u_colormap (
    .raw (bus.rd_data),
    .rgb (pix_next)
  );
`else
  assign pix_next = bus.rd_data;
`endif

  assign pop       = pix_valid & bus.pix_ready;
  assign slot_free = !pix_valid | bus.pix_ready;
  assign last_pix  = (x == ADDR_W'(WIDTH - 1)) && (y == ADDR_W'(HEIGHT - 1));
  assign busy      = (state != IDLE);

  assign bus.rd_solver_id = sid;
  assign bus.rd_addr      = addr;
  assign bus.pix_valid    = pix_valid;
  assign bus.pix_data     = pix_data;
  assign bus.pix_sof      = pix_sof;
  assign bus.pix_eol      = pix_eol;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      sid        <= '0;
      addr       <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE && !solver_done) begin
        state     <= IDLE;
        pix_valid <= 1'b0;
      end else begin
        // A pop clears the slot unless CAPTURE refills it on the same edge.
        if (pop) pix_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (start && solver_done) begin
              x     <= '0;
              y     <= '0;
              sid   <= '0;
              addr  <= '0;
              state <= ISSUE;
            end
          end
          ISSUE: state <= CAPTURE;
          CAPTURE: begin
            if (slot_free) begin
              pix_valid <= 1'b1;
              pix_data  <= pix_next;
              pix_sof   <= (x == '0) && (y == '0);
              pix_eol   <= (x == ADDR_W'(WIDTH - 1));
              if (sid == SID_W'(NUM_SOLVERS - 1)) begin
                sid  <= '0;
                addr <= addr + 1'b1;
              end else begin
                sid <= sid + 1'b1;
              end
              if (x == ADDR_W'(WIDTH - 1)) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
              state <= last_pix ? FLUSH : ISSUE;
            end
          end
          FLUSH: begin
            if (slot_free) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout (4 solvers, 4x2 frame) with a registered RAM model.
module tb_frame_scanout;
  localparam int NS   = 4;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic solver_done = 1'b0;
  logic busy, frame_done;
  logic [7:0] off = 8'd0;
  logic [7:0] ram_q [NS];

  int n_tests = 0;
  int n_fail  = 0;

  frame_scanout_if bus ();

  frame_scanout #(.NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .solver_done (solver_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  // Each solver RAM registers word(a) = 8*a + sid + off for the presented address.
  always @(posedge clock)
    for (int s = 0; s < NS; s++)
      ram_q[s] <= 8'(int'(bus.rd_addr) * 8 + s + int'(off));

  assign bus.rd_data = ram_q[bus.rd_solver_id[1:0]];

  function automatic logic [7:0] exp_pix(input int p);
    logic [7:0] w;
    w = 8'((p / NS) * 8 + (p % NS) + int'(off));
`ifdef SCANOUT_COLORMAP_EN
    if (w[7]) return 8'h00;
    return {w[2:0], w[5:3], w[6], w[6]};
`else
    return w;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({bus.pix_valid, busy, frame_done, bus.pix_sof, bus.pix_eol} !== 5'b0 ||
        bus.pix_data !== 8'h00 || bus.rd_addr !== 19'd0 || bus.rd_solver_id !== 6'd0) begin
      n_fail++;
      $display("FAIL %s: valid=%b busy=%b done=%b sof=%b eol=%b data=%h addr=%0d sid=%0d, required all 0",
               tag, bus.pix_valid, busy, frame_done, bus.pix_sof, bus.pix_eol,
               bus.pix_data, bus.rd_addr, bus.rd_solver_id);
    end
  endtask

  // mode 0: ready always high, 1: ready 1 cycle in 4, 2: random ready.
  task automatic run_frame(input int mode, input bit check_timing);
    int got = 0, nfd = 0, cyc = 1, post = 0;
    bit stalled = 0, done_seen = 0, rdy;
    logic [7:0] pd;
    logic ps, pe;
    off = 8'($urandom);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (cyc < 400 && !(done_seen && post >= 3)) begin
      if (stalled) begin
        n_tests++;
        if (bus.pix_valid !== 1'b1 || bus.pix_data !== pd || bus.pix_sof !== ps || bus.pix_eol !== pe) begin
          n_fail++;
          $display("FAIL stall_stable: valid=%b data=%h sof=%b eol=%b, required 1 %h %b %b",
                   bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol, pd, ps, pe);
        end
      end
      if (frame_done === 1'b1) begin
        nfd++;
        done_seen = 1;
        n_tests++;
        if (got != NPIX) begin
          n_fail++;
          $display("FAIL early_done: pixels=%0d, required %0d", got, NPIX);
        end
      end
      if (done_seen) post++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.pix_ready = rdy;
      if (bus.pix_valid === 1'b1 && rdy) begin
        n_tests++;
        if (got >= NPIX) begin
          n_fail++;
          $display("FAIL extra_pixel: index=%0d, required < %0d", got, NPIX);
        end else if (bus.pix_data !== exp_pix(got) || bus.pix_sof !== (got == 0) ||
                     bus.pix_eol !== (got % W == W - 1)) begin
          n_fail++;
          $display("FAIL pixel%0d: data=%h sof=%b eol=%b, required %h %b %b", got,
                   bus.pix_data, bus.pix_sof, bus.pix_eol, exp_pix(got), got == 0, got % W == W - 1);
        end
        if (check_timing) begin
          n_tests++;
          if (cyc != 3 + 2 * got) begin
            n_fail++;
            $display("FAIL timing%0d: cycle=%0d, required %0d", got, cyc, 3 + 2 * got);
          end
        end
        got++;
      end
      stalled = (bus.pix_valid === 1'b1) && !rdy;
      pd = bus.pix_data; ps = bus.pix_sof; pe = bus.pix_eol;
      @(negedge clock);
      cyc++;
    end
    n_tests++;
    if (!done_seen || got != NPIX || nfd != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: pixels=%0d done_pulses=%0d busy=%b, required %0d 1 0",
               got, nfd, busy, NPIX);
    end
    bus.pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.pix_ready = 1'b0;
    reset = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check_all_zero("after_release");
  endtask

  task automatic test_stream();
    solver_done = 1'b1;
    run_frame(0, 1'b1);
    run_frame(1, 1'b0);
  endtask

  task automatic test_no_done();
    solver_done = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL no_done_idle: busy=%b valid=%b, required 0 0", busy, bus.pix_valid);
      end
      @(negedge clock);
    end
    solver_done = 1'b1;
    run_frame(0, 1'b1);
  endtask

  task automatic test_abort();
    int got = 0;
    solver_done = 1'b1;
    off = 8'($urandom);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    bus.pix_ready = 1'b1;
    for (int c = 0; c < 50 && got < 3; c++) begin
      if (bus.pix_valid === 1'b1) got++;
      @(negedge clock);
    end
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL abort_reach: pixels=%0d, required 3", got);
    end
    solver_done = 1'b0;
    @(negedge clock);
    n_tests++;
    if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: valid=%b busy=%b, required 0 0", bus.pix_valid, busy);
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (frame_done !== 1'b0 || bus.pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet: done=%b valid=%b, required 0 0", frame_done, bus.pix_valid);
      end
      @(negedge clock);
    end
    bus.pix_ready = 1'b0;
    solver_done = 1'b1;
    run_frame(2, 1'b0);
  endtask

  task automatic test_reset_mid();
    solver_done = 1'b1;
    off = 8'($urandom);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge clock);
    check_all_zero("reset_held");
    reset = 1'b1;
    bus.pix_ready = 1'b0;
    run_frame(0, 1'b1);
  endtask

  task automatic test_back_to_back();
    solver_done = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_no_done();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
